// File: rtl/async_transmitter.sv
// async_transmitter: 8N1 UART transmit path with a small byte FIFO and a
// fractional-accumulator baud generator; queued bytes are sent back-to-back.
module async_transmitter #(
    parameter int ClkFrequency          = 100000000,
    parameter int Baud                  = 115200,
    parameter int BaudGeneratorAccWidth = 16,
    parameter int FifoDepthLog2         = 4,
    parameter int StopBits              = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     TxD_start,
    input  logic [7:0]               TxD_data,
    output logic                     TxD_full,
    output logic [FifoDepthLog2:0]   TxD_count,
    output logic                     TxD_busy,
    output logic                     TxD_done,
    output logic                     TxD
);

    localparam int AccW  = BaudGeneratorAccWidth;
    localparam int CntW  = FifoDepthLog2 + 1;
    localparam int Depth = 2 ** FifoDepthLog2;

    // Increment rounded to nearest; 64-bit math keeps Baud<<(AccW-4) from overflowing.
    localparam longint IncL = ((longint'(Baud) << (AccW - 4)) + (longint'(ClkFrequency) >> 5))
                              / (longint'(ClkFrequency) >> 4);
    localparam logic [AccW:0]          Inc      = (AccW + 1)'(IncL);
    localparam logic [CntW-1:0]        CntOne   = CntW'(1);
    localparam logic [CntW-1:0]        DepthCnt = CntW'(Depth);
    localparam logic [FifoDepthLog2-1:0] PtrOne = FifoDepthLog2'(1);

    typedef enum logic [3:0] {
        IDLE, START, D0, D1, D2, D3, D4, D5, D6, D7, STOP1, STOP2
    } stateType;

    stateType state, stateNext;

    logic [AccW:0]              acc;
    logic                       baudTick;
    logic [7:0]                 mem [Depth];
    logic [FifoDepthLog2-1:0]   wrPtr;
    logic [FifoDepthLog2-1:0]   rdPtr;
    logic [CntW-1:0]            countNext;
    logic                       push;
    logic                       pop;
    logic [7:0]                 sr;
    logic [7:0]                 srNext;
    logic                       txdNext;
    logic                       busyNext;
    logic                       doneNext;
    logic                       frameEnd;

    assign baudTick = acc[AccW];

    // A full FIFO refuses the write even when a pop frees a slot this cycle.
    assign push = TxD_start && !TxD_full;

    always_comb begin
        countNext = TxD_count;
        if (push && !pop) begin
            countNext = TxD_count + CntOne;
        end else if (!push && pop) begin
            countNext = TxD_count - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= TxD_data;
        end
    end

    always_comb begin
        stateNext = state;
        txdNext   = TxD;
        busyNext  = TxD_busy;
        doneNext  = 1'b0;
        srNext    = sr;
        pop       = 1'b0;
        frameEnd  = 1'b0;

        case (state)
            IDLE: begin
                if (TxD_count != '0) begin
                    pop       = 1'b1;
                    srNext    = mem[rdPtr];
                    txdNext   = 1'b0;
                    busyNext  = 1'b1;
                    stateNext = START;
                end
            end
            // sr shifts right so the next data bit is always at sr[0].
            START, D0, D1, D2, D3, D4, D5, D6: begin
                if (baudTick) begin
                    txdNext   = sr[0];
                    srNext    = {1'b1, sr[7:1]};
                    stateNext = stateType'(state + 4'd1);
                end
            end
            D7: begin
                if (baudTick) begin
                    txdNext   = 1'b1;
                    stateNext = STOP1;
                end
            end
            STOP1: begin
                if (baudTick) begin
                    if (StopBits == 2) begin
                        txdNext   = 1'b1;
                        stateNext = STOP2;
                    end else begin
                        frameEnd = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (baudTick) begin
                    frameEnd = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                txdNext   = 1'b1;
                busyNext  = 1'b0;
            end
        endcase

        if (frameEnd) begin
            doneNext = 1'b1;
            if (TxD_count != '0) begin
                pop       = 1'b1;
                srNext    = mem[rdPtr];
                txdNext   = 1'b0;
                stateNext = START;
            end else begin
                txdNext   = 1'b1;
                busyNext  = 1'b0;
                stateNext = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            TxD       <= 1'b1;
            TxD_busy  <= 1'b0;
            TxD_done  <= 1'b0;
            sr        <= '0;
            acc       <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            TxD_count <= '0;
            TxD_full  <= 1'b0;
        end else begin
            state     <= stateNext;
            TxD       <= txdNext;
            TxD_busy  <= busyNext;
            TxD_done  <= doneNext;
            sr        <= srNext;
            // Held at zero while idle so every first start bit is timed from a clean phase.
            acc       <= (state == IDLE) ? '0 : ({1'b0, acc[AccW-1:0]} + Inc);
            if (push) begin
                wrPtr <= wrPtr + PtrOne;
            end
            if (pop) begin
                rdPtr <= rdPtr + PtrOne;
            end
            TxD_count <= countNext;
            TxD_full  <= (countNext == DepthCnt);
        end
    end

endmodule

// File: tb/tb_async_transmitter.sv
// Bench for async_transmitter: default-rate instance for bit timing, plus
// fast-rate instances (16 clk per bit) for framing, FIFO and reset behaviour.
module tb_async_transmitter;

    localparam int FastClk  = 1600000;
    localparam int FastBaud = 100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rstA = 1'b1, startA = 1'b0, fullA, busyA, doneA, txdA;
    logic [7:0] dataA = 8'h00;
    logic [4:0] countA;
    logic       rstB = 1'b1, startB = 1'b0, fullB, busyB, doneB, txdB;
    logic [7:0] dataB = 8'h00;
    logic [4:0] countB;
    logic       rstC = 1'b1, startC = 1'b0, fullC, busyC, doneC, txdC;
    logic [7:0] dataC = 8'h00;
    logic [4:0] countC;

    async_transmitter dutA (
        .clk(clk), .reset(rstA), .TxD_start(startA), .TxD_data(dataA),
        .TxD_full(fullA), .TxD_count(countA), .TxD_busy(busyA), .TxD_done(doneA), .TxD(txdA)
    );

    async_transmitter #(.ClkFrequency(FastClk), .Baud(FastBaud), .StopBits(1)) dutB (
        .clk(clk), .reset(rstB), .TxD_start(startB), .TxD_data(dataB),
        .TxD_full(fullB), .TxD_count(countB), .TxD_busy(busyB), .TxD_done(doneB), .TxD(txdB)
    );

    async_transmitter #(.ClkFrequency(FastClk), .Baud(FastBaud), .StopBits(2)) dutC (
        .clk(clk), .reset(rstC), .TxD_start(startC), .TxD_data(dataC),
        .TxD_full(fullC), .TxD_count(countC), .TxD_busy(busyC), .TxD_done(doneC), .TxD(txdC)
    );

    int doneCntA = 0, doneCntB = 0, doneCntC = 0;
    always @(negedge clk) begin
        if (doneA === 1'b1) doneCntA <= doneCntA + 1;
        if (doneB === 1'b1) doneCntB <= doneCntB + 1;
        if (doneC === 1'b1) doneCntC <= doneCntC + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkRange(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard of expected 10-bit line images: bit0 start, bits1..8 data LSB first, bit9 stop.
    logic [9:0] sbQ[$];
    int         startTimes[32];

    function automatic logic [9:0] lineOf(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    task automatic writeBurstB(input logic [7:0] bytes [32], input int n);
        @(posedge clk); #1;
        startB = 1'b1;
        dataB  = bytes[0];
        for (int i = 1; i < n; i++) begin
            @(posedge clk); #1;
            dataB = bytes[i];
        end
        @(posedge clk); #1;
        startB = 1'b0;
        dataB  = 8'($urandom);
    endtask

    task automatic recvFrameB(output logic [9:0] line, output int startCyc, output bit ok);
        ok = 1'b0;
        line = '0;
        startCyc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (txdB === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        startCyc = cyc;
        repeat (8) @(negedge clk);
        line[0] = txdB;
        for (int b = 1; b < 10; b++) begin
            repeat (16) @(negedge clk);
            line[b] = txdB;
        end
    endtask

    task automatic rxCheckB(input string name, input int n);
        logic [9:0] line;
        logic [9:0] exp;
        int         sc;
        bit         ok;
        for (int k = 0; k < n; k++) begin
            recvFrameB(line, sc, ok);
            check($sformatf("%s frame %0d seen", name, k), ok, 1);
            if (!ok) return;
            startTimes[k] = sc;
            check($sformatf("%s frame %0d queued", name, k), (sbQ.size() > 0), 1);
            if (sbQ.size() > 0) begin
                exp = sbQ.pop_front();
                check($sformatf("%s frame %0d line", name, k), line, exp);
            end
        end
    endtask

    task automatic waitIdleB(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busyB === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, " idle reached"}, ok, 1);
        @(posedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vecType;

    vecType     vecs[6];
    logic [7:0] burst[32];

    initial begin
        int base;
        int bad;
        int lowCnt;
        int highCnt;
        int doneCyc;
        int nTr;
        int tr[16];
        logic prevTxd;
        logic prevBusy;
        bit ok;

        vecs[0] = '{8'h55, 10'b1010101010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h80, 10'b1100000000};
        vecs[4] = '{8'h01, 10'b1000000010};
        vecs[5] = '{8'hA3, 10'b1101000110};

        repeat (3) @(posedge clk);
        #1;
        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        @(negedge clk);
        check("reset txd", txdB, 1);
        check("reset busy", busyB, 0);
        check("reset done", doneB, 0);
        check("reset count", countB, 0);
        check("reset full", fullB, 0);

        // Quiet line after reset.
        bad = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (txdA !== 1'b1 || busyA !== 1'b0 || doneA !== 1'b0 || countA !== 5'd0 || fullA !== 1'b0) bad++;
            if (txdB !== 1'b1 || busyB !== 1'b0 || doneB !== 1'b0 || countB !== 5'd0 || fullB !== 1'b0) bad++;
            if (txdC !== 1'b1 || busyC !== 1'b0 || doneC !== 1'b0 || countC !== 5'd0 || fullC !== 1'b0) bad++;
        end
        check("idle violations", bad, 0);

        // Start-bit latency and input latching.
        sbQ.push_back(lineOf(8'h3C));
        @(posedge clk); #1;
        startB = 1'b1; dataB = 8'h3C;
        @(posedge clk); #1;
        startB = 1'b0; dataB = 8'hC3;
        @(negedge clk);
        check("lat1 txd", txdB, 1);
        check("lat1 count", countB, 1);
        check("lat1 busy", busyB, 0);
        @(negedge clk);
        check("lat2 txd", txdB, 0);
        check("lat2 busy", busyB, 1);
        check("lat2 count", countB, 0);
        rxCheckB("latch", 1);
        waitIdleB("latch");

        for (int v = 0; v < 6; v++) begin
            base = doneCntB;
            sbQ.push_back(vecs[v].line);
            burst[0] = vecs[v].data;
            fork
                writeBurstB(burst, 1);
                rxCheckB($sformatf("vec%0d", v), 1);
            join
            waitIdleB($sformatf("vec%0d", v));
            check($sformatf("vec%0d done pulses", v), doneCntB - base, 1);
        end

        // Back-to-back frames with no idle gap.
        base = doneCntB;
        burst[0] = 8'hA3; burst[1] = 8'h0F;
        sbQ.push_back(lineOf(8'hA3));
        sbQ.push_back(lineOf(8'h0F));
        fork
            writeBurstB(burst, 2);
            rxCheckB("b2b", 2);
        join
        check("b2b start spacing", startTimes[1] - startTimes[0], 161);
        waitIdleB("b2b");
        check("b2b done pulses", doneCntB - base, 2);

        // Overfill: 18 writes, the last one lands on a full FIFO and is dropped.
        base = doneCntB;
        for (int i = 0; i < 18; i++) burst[i] = 8'(i);
        for (int i = 0; i < 17; i++) sbQ.push_back(lineOf(8'(i)));
        fork
            begin
                writeBurstB(burst, 18);
                @(negedge clk);
                check("fill count", countB, 16);
                check("fill full", fullB, 1);
            end
            rxCheckB("fill", 17);
        join
        waitIdleB("fill");
        check("fill done pulses", doneCntB - base, 17);
        check("fill scoreboard empty", sbQ.size(), 0);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (txdB !== 1'b1) bad++;
        end
        check("fill no extra frame", bad, 0);

        // Reset in the middle of D3 of 0xFF with five bytes behind it.
        burst[0] = 8'hFF;
        for (int i = 1; i < 6; i++) burst[i] = 8'(i);
        writeBurstB(burst, 6);
        repeat (65) @(posedge clk);
        @(negedge clk);
        check("pre-reset busy", busyB, 1);
        check("pre-reset count", countB, 5);
        check("pre-reset txd", txdB, 1);
        @(posedge clk); #1;
        rstB = 1'b1;
        @(posedge clk); #1;
        rstB = 1'b0;
        @(negedge clk);
        check("mid reset txd", txdB, 1);
        check("mid reset busy", busyB, 0);
        check("mid reset count", countB, 0);
        check("mid reset full", fullB, 0);
        base = doneCntB;
        bad = 0;
        repeat (400) begin
            @(negedge clk);
            if (txdB !== 1'b1 || busyB !== 1'b0) bad++;
        end
        check("post reset quiet", bad, 0);
        check("post reset done pulses", doneCntB - base, 0);
        sbQ.push_back(lineOf(8'h96));
        burst[0] = 8'h96;
        fork
            writeBurstB(burst, 1);
            rxCheckB("post reset", 1);
        join
        waitIdleB("post reset");

        // Two stop bits.
        @(posedge clk); #1;
        startC = 1'b1; dataC = 8'h00;
        @(posedge clk); #1;
        startC = 1'b0; dataC = 8'hFF;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txdC === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("stop2 start seen", ok, 1);
        lowCnt = 1;
        while (txdC === 1'b0 && lowCnt < 400) begin
            @(negedge clk);
            if (txdC === 1'b0) lowCnt++;
        end
        check("stop2 low cycles", lowCnt, 145);
        highCnt = 0;
        while (doneC !== 1'b1 && highCnt < 400) begin
            if (txdC === 1'b1) highCnt++;
            @(negedge clk);
        end
        check("stop2 high cycles", highCnt, 32);
        check("stop2 busy at done", busyC, 0);
        check("stop2 txd at done", txdC, 1);
        @(negedge clk);
        check("stop2 done width", doneC, 0);

        // Default-rate bit timing with 0x55 (every bit toggles the line).
        base = doneCntA;
        @(posedge clk); #1;
        startA = 1'b1; dataA = 8'h55;
        @(posedge clk); #1;
        startA = 1'b0; dataA = 8'h00;
        nTr = 0;
        doneCyc = -1;
        prevTxd = 1'b1;
        prevBusy = 1'b0;
        bad = 0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (doneA === 1'b1) begin
                doneCyc = cyc;
                break;
            end
            if (txdA !== prevTxd) begin
                if (nTr < 16) tr[nTr] = cyc;
                if (nTr == 0 && txdA !== 1'b0) bad++;
                nTr++;
            end
            prevTxd = txdA;
            prevBusy = busyA;
        end
        check("def done seen", (doneCyc >= 0), 1);
        check("def transitions", nTr, 10);
        check("def first edge falls", bad, 0);
        check("def busy before done", prevBusy, 1);
        check("def busy at done", busyA, 0);
        if (nTr == 10 && doneCyc >= 0) begin
            for (int k = 0; k < 9; k++) begin
                checkRange($sformatf("def bit%0d len", k), tr[k+1] - tr[k], 872, 876);
            end
            checkRange("def stop len", doneCyc - tr[9], 872, 876);
            checkRange("def frame len", doneCyc - tr[0], 8725, 8755);
        end
        @(negedge clk);
        check("def done width", doneA, 0);
        @(posedge clk);
        check("def done pulses", doneCntA - base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
